// File: rtl/vm_dispenser_if.sv
// ---------------------------------------------------------------------------
// vm_dispenser_if
// Purpose : groups the result-burst input, the coin hopper handshake and the
//           dispenser status outputs of vm_dispenser into one bundle.
// Signals : in_valid/in_result/in_num   six-beat result burst (one beat per
//                                       cycle while in_valid is high)
//           coin_valid/coin_type/coin_ready  hopper handshake
//           item_valid/item_id          one-cycle item release pulse
//           total_sold/busy/done/frame_err/overrun  status
//
// Handshake: a coin transfers on every rising clk edge where coin_valid and
// coin_ready are both high. While coin_valid is high and coin_ready is low,
// coin_type is held stable and coin_valid does not drop. coin_ready may be
// high while coin_valid is low; nothing transfers then. in_valid has no
// ready: every beat is consumed or ignored in the cycle it is presented.
// ---------------------------------------------------------------------------
interface vm_dispenser_if;
    logic       in_valid;
    logic [3:0] in_result;
    logic [5:0] in_num;
    logic       coin_ready;
    logic       item_valid;
    logic [2:0] item_id;
    logic       coin_valid;
    logic [2:0] coin_type;
    logic [8:0] total_sold;
    logic       busy;
    logic       done;
    logic       frame_err;
    logic       overrun;

    // master drives the burst and the hopper ready, slave is the dispenser
    modport master (
        output in_valid, in_result, in_num, coin_ready,
        input  item_valid, item_id, coin_valid, coin_type,
        input  total_sold, busy, done, frame_err, overrun
    );

    modport slave (
        input  in_valid, in_result, in_num, coin_ready,
        output item_valid, item_id, coin_valid, coin_type,
        output total_sold, busy, done, frame_err, overrun
    );
endinterface

// File: rtl/vm_dispenser.sv
// ---------------------------------------------------------------------------
// vm_dispenser
// Purpose : captures a six-beat vending-machine result burst (item id plus
//           change counts for 50/20/10/5/1 coins), releases the item, then
//           pays out the change one coin at a time, largest first.
// Ports   : clk        rising-edge clock
//           rst_n      asynchronous active-low reset
//           bus        vm_dispenser_if.slave (burst, hopper, status)
//           dbg_state  current FSM state (S_IDLE=0 .. S_DONE=4)
// ---------------------------------------------------------------------------
module vm_dispenser (
    input  logic                  clk,
    input  logic                  rst_n,
    vm_dispenser_if.slave         bus,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_ITEM    = 3'd2,
        S_COIN    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      beat_q, beat_d;       // index of the next beat in CAPTURE
    logic [2:0]      item_q, item_d;
    logic [4:0][3:0] cnt_q, cnt_d;         // [0]=50 ... [4]=1
    logic [8:0]      sum_q, sum_d;
    logic [8:0]      total_q, total_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            ign_q, ign_d;         // previous cycle was an ignored beat

    logic            any_coin;
    logic [2:0]      sel_idx;
    logic [4:0][3:0] cnt_rem;              // counts after paying the selected coin
    logic            dispensing;

    // Highest denomination with a nonzero count; descending loop so the
    // lowest index (largest coin) is the final assignment.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (cnt_q[i] != 4'd0) sel_idx = 3'(i);
        end
        any_coin          = (cnt_q != '0);
        cnt_rem           = cnt_q;
        cnt_rem[sel_idx]  = cnt_q[sel_idx] - 4'd1;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        item_d      = item_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        total_d     = total_q;
        frame_err_d = 1'b0;

        // Only the first beat of a run of ignored beats flags an overrun.
        dispensing  = (state_q == S_ITEM) || (state_q == S_COIN) || (state_q == S_DONE);
        ign_d       = dispensing && bus.in_valid;
        overrun_d   = dispensing && bus.in_valid && !ign_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    item_d  = bus.in_result[2:0];
                    sum_d   = {3'b000, bus.in_num};
                    cnt_d   = '0;
                    beat_d  = 3'd1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (bus.in_valid) begin
                    cnt_d[beat_q - 3'd1] = bus.in_result;
                    sum_d  = sum_q + {3'b000, bus.in_num};
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd5) begin
                        total_d = sum_q + {3'b000, bus.in_num};
                        state_d = S_ITEM;
                    end
                end else begin
                    // truncated frame: drop everything captured so far
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    sum_d       = '0;
                    beat_d      = '0;
                    item_d      = '0;
                    state_d     = S_IDLE;
                end
            end
            S_ITEM: begin
                state_d = S_COIN;
            end
            S_COIN: begin
                if (!any_coin) begin
                    state_d = S_DONE;
                end else if (bus.coin_ready) begin
                    cnt_d = cnt_rem;
                    // leave straight after the last coin so done follows it
                    if (cnt_rem == '0) state_d = S_DONE;
                end
            end
            S_DONE: begin
                beat_d  = '0;
                sum_d   = '0;
                item_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            item_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            total_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            ign_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            item_q      <= item_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            total_q     <= total_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            ign_q       <= ign_d;
        end
    end

    assign bus.item_valid = (state_q == S_ITEM) && (item_q != 3'd0);
    assign bus.item_id    = bus.item_valid ? item_q : 3'd0;
    assign bus.coin_valid = (state_q == S_COIN) && any_coin;
    assign bus.coin_type  = bus.coin_valid ? (sel_idx + 3'd1) : 3'd0;
    assign bus.total_sold = total_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign dbg_state      = state_q;

endmodule
